// File: rtl/pkmc_sdram_refsched_pkg.sv
// Purpose : shared SDRAM refresh-scheduler defines: FSM state encoding,
//           SDRAM command encodings and default timing constants.
// Ports   : none (package).
package pkmc_sdram_refsched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACCESS    = 3'd1,
    ST_PRECHG    = 3'd2,
    ST_TRP_WAIT  = 3'd3,
    ST_AREF      = 3'd4,
    ST_TRFC_WAIT = 3'd5
  } state_e;

  // SDRAM command bus encodings; 2'b11 is reserved and never driven.
  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_PALL = 2'b01;
  localparam logic [1:0] CMD_AREF = 2'b10;

  localparam int unsigned DEF_T_RP      = 2;
  localparam int unsigned DEF_T_RFC     = 7;
  localparam int unsigned DEF_MAX_PEND  = 8;
  localparam int unsigned DEF_BURST_THR = 4;

  // Wait-counter width: clog2 of the larger timing value, at least one bit.
  // A counter of this width holds (max - 1), which is the largest reload.
  function automatic int unsigned wait_w(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pkmc_sdram_refpend.sv
// Purpose : saturating up/down counter of owed refreshes plus sticky overflow.
// Latency : count and flag update one cycle after inc_i/dec_i.
// Backpr. : none; an increment at saturation is dropped and sets ovf_o.
// Ports   : clk, rst_n (async active-low), inc_i, dec_i, cnt_o[3:0], ovf_o.
module pkmc_sdram_refpend #(
  parameter int unsigned MAX_PEND = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] cnt_o,
  output logic       ovf_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_PEND);

  logic [3:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc_i && !dec_i) begin
      if (cnt_q == MAX_CNT) ovf_d = 1'b1;  // refresh lost, remember it until reset
      else                  cnt_d = cnt_q + 4'd1;
    end else if (dec_i && !inc_i && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/pkmc_sdram_refsched.sv
// Purpose : SDRAM auto-refresh scheduler arbitrating refresh vs. one access requester.
// Latency : grant and commands are registered, one cycle after the IDLE decision.
// Backpr. : acc_req waits while refresh owns the bus; refresh never preempts an access.
// Ports   : clk, rst_n (async active-low), ref_tick, acc_req, acc_done in;
//           acc_gnt, cmd[1:0], ref_busy, pend_cnt[3:0], ref_ovf out.
// Config  : define PKMC_REF_BURST_EN for postponed-burst refresh (access preferred
//           until BURST_THR owed, then one PALL followed by back-to-back AREFs).
module pkmc_sdram_refsched
  import pkmc_sdram_refsched_pkg::*;
#(
  parameter int unsigned T_RP      = DEF_T_RP,
  parameter int unsigned T_RFC     = DEF_T_RFC,
  parameter int unsigned MAX_PEND  = DEF_MAX_PEND,
  parameter int unsigned BURST_THR = DEF_BURST_THR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ref_tick,
  input  logic       acc_req,
  input  logic       acc_done,
  output logic       acc_gnt,
  output logic [1:0] cmd,
  output logic       ref_busy,
  output logic [3:0] pend_cnt,
  output logic       ref_ovf
);

  if (T_RP < 1 || T_RFC < 1 || MAX_PEND < 1 || MAX_PEND > 15 ||
      BURST_THR < 1 || BURST_THR > MAX_PEND) begin : g_bad_param
    $error("pkmc_sdram_refsched: parameter out of range");
  end

  localparam int unsigned    WW      = wait_w(T_RP, T_RFC);
  localparam logic [WW-1:0]  TRP_LD  = WW'(T_RP - 1);
  localparam logic [WW-1:0]  TRFC_LD = WW'(T_RFC - 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          rfc_done;

  pkmc_sdram_refpend #(.MAX_PEND(MAX_PEND)) u_refpend (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (ref_tick),
    .dec_i (cmd_q == CMD_AREF),
    .cnt_o (pend_cnt),
    .ovf_o (ref_ovf)
  );

`ifdef PKMC_REF_BURST_EN
  localparam logic [3:0] BURST_THR4 = 4'(BURST_THR);
  logic more_ref;
  // In the AREF cycle itself the counter still includes the refresh being issued.
  assign more_ref = (pend_cnt > ((state_q == ST_AREF) ? 4'd1 : 4'd0));
`endif

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    rfc_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
`ifdef PKMC_REF_BURST_EN
        if (pend_cnt >= BURST_THR4 || (pend_cnt != 4'd0 && !acc_req)) state_d = ST_PRECHG;
        else if (acc_req)                                              state_d = ST_ACCESS;
`else
        if (pend_cnt != 4'd0) state_d = ST_PRECHG;
        else if (acc_req)     state_d = ST_ACCESS;
`endif
      end
      ST_ACCESS: if (acc_done) state_d = ST_IDLE;
      ST_PRECHG: begin
        if (T_RP == 1) state_d = ST_AREF;
        else begin
          state_d = ST_TRP_WAIT;
          wait_d  = TRP_LD;
        end
      end
      ST_TRP_WAIT: begin
        if (wait_q <= WW'(1)) begin
          state_d = ST_AREF;
          wait_d  = '0;
        end else wait_d = wait_q - WW'(1);
      end
      ST_AREF: begin
        if (T_RFC == 1) rfc_done = 1'b1;
        else begin
          state_d = ST_TRFC_WAIT;
          wait_d  = TRFC_LD;
        end
      end
      ST_TRFC_WAIT: begin
        if (wait_q <= WW'(1)) begin
          rfc_done = 1'b1;
          wait_d   = '0;
        end else wait_d = wait_q - WW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (rfc_done) begin
`ifdef PKMC_REF_BURST_EN
      // Bank is still precharged: chain the next refresh without another PALL.
      state_d = more_ref ? ST_AREF : ST_IDLE;
`else
      state_d = ST_IDLE;
`endif
    end

    // Outputs are registered from the next state so they align with state_q.
    gnt_d  = (state_d == ST_ACCESS);
    busy_d = (state_d == ST_PRECHG) || (state_d == ST_TRP_WAIT) ||
             (state_d == ST_AREF)   || (state_d == ST_TRFC_WAIT);
    cmd_d  = (state_d == ST_PRECHG) ? CMD_PALL :
             (state_d == ST_AREF)   ? CMD_AREF : CMD_NOP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      cmd_q   <= CMD_NOP;
      gnt_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cmd_q   <= cmd_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign cmd      = cmd_q;
  assign acc_gnt  = gnt_q;
  assign ref_busy = busy_q;

endmodule

// File: doc/pkmc_sdram_refsched.md
PKMC_SDRAM_REFSCHED -- requirements
Module: pkmc_sdram_refsched

Interface
REQ-001 SHALL have parameter T_RP, default 2: precharge-to-refresh delay in clk cycles, minimum 1.
REQ-002 SHALL have parameter T_RFC, default 7: refresh-to-next-command delay in clk cycles, minimum 1.
REQ-003 SHALL have parameter MAX_PEND, default 8: saturation value of the pending-refresh counter, range 1..15.
REQ-004 SHALL have parameter BURST_THR, default 4: pending count that forces a refresh burst, range 1..MAX_PEND.
REQ-005 SHALL have port clk, input, 1: sole clock, all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port ref_tick, input, 1: single-cycle pulse from the refresh interval counter, one per refresh owed.
REQ-008 SHALL have port acc_req, input, 1: memory-access requester wants the SDRAM, held high until granted.
REQ-009 SHALL have port acc_done, input, 1: single-cycle pulse ending the granted access.
REQ-010 SHALL have port acc_gnt, output, 1: access owns the SDRAM command bus.
REQ-011 SHALL have port cmd, output, 2: 00 NOP, 01 PRECHARGE_ALL, 10 AUTO_REFRESH, 11 reserved (never driven).
REQ-012 SHALL have port ref_busy, output, 1: high in any refresh-sequence state.
REQ-013 SHALL have port pend_cnt, output, 4: current pending-refresh count.
REQ-014 SHALL have port ref_ovf, output, 1: sticky flag, refresh lost to saturation.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, PRECHG, TRP_WAIT, AREF, TRFC_WAIT.
REQ-016 pend_cnt SHALL increment on ref_tick, decrement when cmd=AUTO_REFRESH; both in the same cycle -> unchanged.
REQ-017 ref_tick with pend_cnt=MAX_PEND and no simultaneous decrement SHALL leave count unchanged and set ref_ovf until reset.
REQ-018 IDLE: pend_cnt>0 -> PRECHG (refresh has priority); else acc_req -> ACCESS; else stay.
REQ-019 acc_gnt SHALL be registered, high exactly while in ACCESS, rising the cycle after the IDLE decision.
REQ-020 ACCESS SHALL be left only on acc_done -> IDLE; refresh never preempts an access.
REQ-021 PRECHG SHALL drive cmd=PRECHARGE_ALL for exactly one cycle, then TRP_WAIT for T_RP-1 cycles (skip if T_RP=1).
REQ-022 AREF SHALL drive cmd=AUTO_REFRESH for exactly one cycle, then TRFC_WAIT for T_RFC-1 cycles (skip if T_RFC=1).
REQ-023 End of TRFC_WAIT SHALL return to IDLE; cmd SHALL be NOP in all other states.
REQ-024 acc_done outside ACCESS SHALL be ignored; acc_req deasserted before grant SHALL cancel the request without effect.
REQ-025 Wait counters SHALL be sized by clog2 of the larger of T_RP, T_RFC and reload on each state entry.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, pend_cnt=0, ref_ovf=0, acc_gnt=0, cmd=NOP, ref_busy=0, wait counter 0.
REQ-027 Reset mid-sequence SHALL abandon the sequence; no refresh credit is retained.

Configuration
REQ-028 Macro PKMC_REF_BURST_EN SHALL select postponed-burst refresh.
REQ-029 Without it: behaviour exactly per REQ-018..023, one PRECHG/AREF pair per pending refresh.
REQ-030 With it: IDLE SHALL prefer acc_req over refresh while pend_cnt<BURST_THR; pend_cnt>=BURST_THR, or pend_cnt>0 with acc_req low, -> PRECHG.
REQ-031 With it: after TRFC_WAIT, pend_cnt>0 SHALL go directly to AREF (no second precharge), draining all pending refreshes before IDLE.

Structure
REQ-032 Command encodings, state encoding and default timing constants SHALL live in the shared pkmc SDRAM defines include.
REQ-033 Single module; one sub-module pkmc_sdram_refpend (saturating up/down pending counter plus ovf flag) is natural and SHALL be used if split.

Verification
REQ-034 Reset, one ref_tick, acc_req low -> PALL at T+2, AREF at T+2+T_RP, IDLE after T_RFC, pend_cnt back to 0.
REQ-035 acc_req granted, ref_tick during access -> no command until acc_done; PALL one cycle after IDLE.
REQ-036 9 ref_ticks while held in ACCESS, MAX_PEND=8 -> pend_cnt=8, ref_ovf=1 and stays 1.
REQ-037 ref_tick coincident with AREF cycle -> pend_cnt unchanged.
REQ-038 PKMC_REF_BURST_EN, 4 ticks during access, acc_req kept high -> one PALL then 4 AREFs spaced T_RFC, acc_gnt only after pend_cnt=0.
REQ-039 rst_n low during TRFC_WAIT with pend_cnt=3 -> immediately IDLE, pend_cnt=0, cmd=NOP.
